// File: rtl/boot_select.sv
// boot_select: warmboot image selector with a button-driven select mode and flash-lock handshake.
// Optional build macro BOOT_LONG_PRESS_EN: a long hold in select mode commits the current image.
`timescale 1ns/1ps
module boot_select #(
    parameter int N_IMG   = 4,
    parameter int DEF_IMG = 2,
    parameter int SEL_IMG = 1,
    parameter int TMR_W   = 24,
    parameter int REARM_W = 18,
    parameter int LONG_W  = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_v,
    input  logic       fl_rdy,
    output logic       fl_go,
    output logic       boot,
    output logic [1:0] boot_sel,
    output logic       sel_active,
    output logic       fl_skip,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        START    = 3'd0,
        WAIT     = 3'd1,
        SEL      = 3'd2,
        SEL_WAIT = 3'd3,
        LOCK     = 3'd4,
        BOOT     = 3'd5
    } state_t;

    localparam logic [1:0] LAST_IMG = 2'(N_IMG - 1);

    state_t           state, state_n;
    logic [TMR_W-1:0] timer;
    logic             btn_q;
    logic             press;
    logic             tick;
    logic             long_hit;
    state_t           commit_state;
    logic [1:0]       next_img;

    // A press is the released->pressed transition of the filtered level.
    assign press        = btn_q & ~btn_v;
    assign tick         = (state == SEL_WAIT) ? timer[REARM_W-1] : timer[TMR_W-1];
    assign commit_state = fl_skip ? BOOT : LOCK;
    assign next_img     = (boot_sel == LAST_IMG) ? 2'd0 : boot_sel + 2'd1;

`ifdef BOOT_LONG_PRESS_EN
    logic [LONG_W-1:0] long_cnt;

    assign long_hit = long_cnt[LONG_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
        end else if (!btn_v && (state == SEL || state == SEL_WAIT)) begin
            long_cnt <= long_cnt + LONG_W'(1);
        end else begin
            long_cnt <= '0;
        end
    end
`else
    // LONG_W only sizes the long-press counter, which is absent in this build.
    logic unused_long_w;

    assign long_hit      = 1'b0;
    assign unused_long_w = (LONG_W > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            START:    state_n = btn_v ? LOCK : WAIT;
            WAIT:     if (btn_v) state_n = SEL_WAIT;
            SEL: begin
                if (press)         state_n = SEL_WAIT;
                else if (long_hit) state_n = commit_state;
                else if (tick)     state_n = commit_state;
            end
            SEL_WAIT: begin
                if (long_hit)  state_n = commit_state;
                else if (tick) state_n = SEL;
            end
            LOCK:     if (fl_rdy) state_n = BOOT;
            BOOT:     state_n = BOOT;
            default:  state_n = START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q    <= 1'b1;
            timer    <= '0;
            boot     <= 1'b0;
            fl_go    <= 1'b0;
            boot_sel <= 2'(DEF_IMG);
            fl_skip  <= 1'b0;
        end else begin
            btn_q <= btn_v;
            timer <= (!btn_v || tick) ? '0 : timer + TMR_W'(1);
            boot  <= boot | (state == BOOT);
            fl_go <= (state_n == LOCK) && (state != LOCK);
            // Image index is frozen outside WAIT/SEL, so LOCK and BOOT never see it move.
            if (state == WAIT) begin
                boot_sel <= 2'(SEL_IMG);
            end else if (state == SEL && press) begin
                boot_sel <= next_img;
                if (boot_sel == 2'd0) fl_skip <= 1'b1;
            end
        end
    end

    assign sel_active = (state == WAIT) || (state == SEL) || (state == SEL_WAIT);
    assign dbg_state  = state;

endmodule

// File: tb/tb_boot_select.sv
// Directed bench for boot_select: boot outcomes are queued as stimulus is driven and checked when boot rises.
`timescale 1ns/1ps
module tb_boot_select;

    localparam int N_IMG   = 3;
    localparam int DEF_IMG = 2;
    localparam int SEL_IMG = 1;
    localparam int TMR_W   = 8;
    localparam int REARM_W = 4;
    localparam int LONG_W  = 10;

    localparam logic [2:0] S_START    = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_SEL      = 3'd2;
    localparam logic [2:0] S_SEL_WAIT = 3'd3;
    localparam logic [2:0] S_LOCK     = 3'd4;
    localparam logic [2:0] S_BOOT     = 3'd5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_v  = 1'b1;
    logic       fl_rdy = 1'b0;
    logic       fl_go;
    logic       boot;
    logic [1:0] boot_sel;
    logic       sel_active;
    logic       fl_skip;
    logic [2:0] dbg_state;

    int total    = 0;
    int bad      = 0;
    int go_total = 0;
    int go_base  = 0;

    // Entry: {one fl_go expected, fl_skip, boot_sel}
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    boot_select #(
        .N_IMG(N_IMG), .DEF_IMG(DEF_IMG), .SEL_IMG(SEL_IMG),
        .TMR_W(TMR_W), .REARM_W(REARM_W), .LONG_W(LONG_W)
    ) dut (
        .clk(clk), .rst(rst), .btn_v(btn_v), .fl_rdy(fl_rdy),
        .fl_go(fl_go), .boot(boot), .boot_sel(boot_sel),
        .sel_active(sel_active), .fl_skip(fl_skip), .dbg_state(dbg_state)
    );

    always @(negedge clk) if (fl_go === 1'b1) go_total++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(dbg_state), 32'(st));
    endtask

    task automatic wait_boot(input int budget, input string tag);
        int n = 0;
        logic [3:0] e;
        while (boot !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_boot"}, 32'(boot), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hf;
        chk({tag, "_sel"}, 32'(boot_sel), 32'(e[1:0]));
        chk({tag, "_skip"}, 32'(fl_skip), 32'(e[2]));
        chk({tag, "_go_count"}, 32'(go_total - go_base), 32'(e[3]));
    endtask

    task automatic do_reset(input logic b);
        rst    = 1'b1;
        btn_v  = b;
        fl_rdy = 1'b0;
        step();
        step();
        chk("rst_state", 32'(dbg_state), 32'(S_START));
        chk("rst_boot", 32'(boot), 32'd0);
        chk("rst_fl_go", 32'(fl_go), 32'd0);
        chk("rst_boot_sel", 32'(boot_sel), 32'(DEF_IMG));
        chk("rst_fl_skip", 32'(fl_skip), 32'd0);
        chk("rst_sel_active", 32'(sel_active), 32'd0);
        go_base = go_total;
        rst = 1'b0;
    endtask

    task automatic press_sel(input string tag);
        wait_state(S_SEL, 64, {tag, "_armed"});
        btn_v = 1'b0;
        step();
        chk({tag, "_to_selwait"}, 32'(dbg_state), 32'(S_SEL_WAIT));
        repeat ($urandom_range(4, 1)) step();
        btn_v = 1'b1;
        step();
    endtask

    initial begin
        int n;

        // Immediate boot: button released through reset.
        do_reset(1'b1);
        exp_q.push_back({1'b1, 1'b0, 2'd2});
        step();
        chk("t1_go", 32'(fl_go), 32'd1);
        chk("t1_lock", 32'(dbg_state), 32'(S_LOCK));
        step();
        chk("t1_go_single", 32'(fl_go), 32'd0);
        repeat (4) step();
        fl_rdy = 1'b1;
        step();
        chk("t1_boot_entry", 32'(dbg_state), 32'(S_BOOT));
        chk("t1_boot_latency", 32'(boot), 32'd0);
        wait_boot(4, "t1");
        fl_rdy = 1'b0;
        repeat (5) step();
        chk("t1_sticky", 32'(boot), 32'd1);
        chk("t1_terminal", 32'(dbg_state), 32'(S_BOOT));

        // Select mode entered and left alone: re-arm, then full timeout.
        do_reset(1'b0);
        step();
        chk("t2_wait", 32'(dbg_state), 32'(S_WAIT));
        chk("t2_active", 32'(sel_active), 32'd1);
        repeat (18) step();
        chk("t2_selimg", 32'(boot_sel), 32'(SEL_IMG));
        btn_v = 1'b1;
        step();
        n = 0;
        while (dbg_state === S_SEL_WAIT && n < 64) begin
            n++;
            step();
        end
        chk("t2_selwait_len", 32'(n), 32'd8);
        n = 0;
        while (dbg_state === S_SEL && n < 400) begin
            n++;
            chk("t2_active_sel", 32'(sel_active), 32'd1);
            step();
        end
        // Timer runs 0..2^(TMR_W-1) inclusive after the clear on entering SEL.
        chk("t2_sel_len", 32'(n), 32'd129);
        chk("t2_go", 32'(fl_go), 32'd1);
        chk("t2_lock", 32'(dbg_state), 32'(S_LOCK));
        exp_q.push_back({1'b1, 1'b0, 2'd1});
        btn_v = 1'b0;
        repeat (2) step();
        btn_v = 1'b1;
        step();
        chk("t2_lock_press_ignored", 32'(boot_sel), 32'd1);
        chk("t2_lock_hold", 32'(dbg_state), 32'(S_LOCK));
        fl_rdy = 1'b1;
        wait_boot(4, "t2");

        // Three presses: 1->2->0, then 0->1 with flash lock skipped.
        do_reset(1'b0);
        fl_rdy = 1'b1;
        step();
        repeat ($urandom_range(10, 3)) step();
        btn_v = 1'b1;
        step();
        press_sel("t3_p1");
        chk("t3_sel_a", 32'(boot_sel), 32'd2);
        press_sel("t3_p2");
        chk("t3_sel_b", 32'(boot_sel), 32'd0);
        chk("t3_skip_b", 32'(fl_skip), 32'd0);
        press_sel("t3_p3");
        chk("t3_sel_c", 32'(boot_sel), 32'd1);
        chk("t3_skip_c", 32'(fl_skip), 32'd1);
        exp_q.push_back({1'b0, 1'b1, 2'd1});
        wait_boot(400, "t3");
        chk("t3_direct_boot", 32'(dbg_state), 32'(S_BOOT));

        // Press lands on the same cycle as the timeout tick.
        do_reset(1'b0);
        step();
        btn_v = 1'b1;
        step();
        wait_state(S_SEL, 64, "t4_sel");
        repeat (128) step();
        chk("t4_still_sel", 32'(dbg_state), 32'(S_SEL));
        btn_v = 1'b0;
        step();
        chk("t4_press_wins", 32'(dbg_state), 32'(S_SEL_WAIT));
        chk("t4_inc", 32'(boot_sel), 32'd2);
        chk("t4_no_go", 32'(fl_go), 32'd0);
        btn_v = 1'b1;
        step();
        chk("t4_go_count", 32'(go_total - go_base), 32'd0);
        wait_state(S_LOCK, 400, "t4_lock");
        chk("t4_go", 32'(fl_go), 32'd1);
        exp_q.push_back({1'b1, 1'b0, 2'd2});
        fl_rdy = 1'b1;
        wait_boot(4, "t4");

        // Long hold after a press in SEL.
        do_reset(1'b0);
        step();
        btn_v = 1'b1;
        step();
        wait_state(S_SEL, 64, "t5_sel");
        btn_v = 1'b0;
        n = 0;
`ifdef BOOT_LONG_PRESS_EN
        while (dbg_state !== S_LOCK && n < 600) begin
            step();
            n++;
        end
        chk("t5_long_len", 32'(n), 32'd513);
        chk("t5_go", 32'(fl_go), 32'd1);
        chk("t5_sel", 32'(boot_sel), 32'd2);
        exp_q.push_back({1'b1, 1'b0, 2'd2});
        repeat (600 - n) step();
        btn_v = 1'b1;
`else
        repeat (600) step();
        chk("t5_held_state", 32'(dbg_state), 32'(S_SEL_WAIT));
        chk("t5_held_no_go", 32'(go_total - go_base), 32'd0);
        chk("t5_held_no_boot", 32'(boot), 32'd0);
        btn_v = 1'b1;
        while (dbg_state !== S_LOCK && n < 400) begin
            step();
            n++;
        end
        // 9 re-arm cycles from a cleared timer, then the 129-cycle select window.
        chk("t5_release_len", 32'(n), 32'd138);
        chk("t5_go", 32'(fl_go), 32'd1);
        chk("t5_sel", 32'(boot_sel), 32'd2);
        exp_q.push_back({1'b1, 1'b0, 2'd2});
`endif
        fl_rdy = 1'b1;
        wait_boot(8, "t5");

        // Reset mid-LOCK and mid-BOOT.
        do_reset(1'b1);
        step();
        chk("t6_go_first", 32'(fl_go), 32'd1);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("t6_abort_state", 32'(dbg_state), 32'(S_START));
        chk("t6_abort_sel", 32'(boot_sel), 32'(DEF_IMG));
        chk("t6_abort_go", 32'(fl_go), 32'd0);
        step();
        go_base = go_total;
        rst = 1'b0;
        step();
        chk("t6_go_fresh", 32'(fl_go), 32'd1);
        chk("t6_lock", 32'(dbg_state), 32'(S_LOCK));
        exp_q.push_back({1'b1, 1'b0, 2'd2});
        fl_rdy = 1'b1;
        wait_boot(6, "t6");
        rst = 1'b1;
        #1;
        chk("t6_boot_abort", 32'(boot), 32'd0);
        chk("t6_boot_abort_state", 32'(dbg_state), 32'(S_START));
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_select.md
BOOT_SELECT -- requirements
Module: boot_select

Interface
REQ-001 SHALL provide parameter N_IMG, default 4, number of selectable warmboot images (legal 2..4).
REQ-002 SHALL provide parameter DEF_IMG, default 2, image booted on immediate (no-select) boot.
REQ-003 SHALL provide parameter SEL_IMG, default 1, image preselected on entering select mode.
REQ-004 SHALL provide parameter TMR_W, default 24, selection-timeout counter width; timeout = 2^(TMR_W-1) cycles.
REQ-005 SHALL provide parameter REARM_W, default 18, re-arm counter width; re-arm = 2^(REARM_W-1) cycles.
REQ-006 SHALL provide parameter LONG_W, default 24, long-press counter width (used only with BOOT_LONG_PRESS_EN).
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 btn_v  input  1  filtered button level, synchronous to clk; 1 = released, 0 = pressed.
REQ-010 fl_rdy  input  1  flash-lock engine done/idle.
REQ-011 fl_go  output  1  single-cycle flash-lock start pulse.
REQ-012 boot  output  1  warmboot request, registered, sticky.
REQ-013 boot_sel  output  2  selected image index.
REQ-014 sel_active  output  1  high while in select mode (WAIT, SEL, SEL_WAIT).
REQ-015 fl_skip  output  1  flash lock will be skipped for this boot.

Function
REQ-016 SHALL implement FSM states START, WAIT, SEL, SEL_WAIT, LOCK, BOOT.
REQ-017 START: btn_v=1 -> LOCK; btn_v=0 -> WAIT (decided on first cycle after reset).
REQ-018 WAIT: remains until btn_v=1, then -> SEL_WAIT.
REQ-019 SEL: press edge (btn_v 1->0, from internal registered copy) -> SEL_WAIT; else timeout tick -> BOOT if fl_skip, else LOCK; press has priority over tick in same cycle.
REQ-020 SEL_WAIT: re-arm tick -> SEL.
REQ-021 LOCK: fl_rdy=1 -> BOOT; BOOT is terminal until rst.
REQ-022 Timer SHALL be TMR_W bits, cleared when btn_v=0 or on tick, else incremented; tick = bit REARM_W-1 in SEL_WAIT, bit TMR_W-1 otherwise.
REQ-023 fl_go SHALL be high exactly one cycle: the cycle the FSM transitions into LOCK from any other state.
REQ-024 boot_sel SHALL load SEL_IMG while in WAIT; in SEL SHALL increment on press edge, wrapping N_IMG-1 -> 0; otherwise hold.
REQ-025 fl_skip SHALL set on a press edge in SEL while boot_sel=0; cleared only by rst.
REQ-026 boot SHALL go high the cycle after the FSM enters BOOT (one-cycle latency) and stay high.
REQ-027 boot_sel SHALL not change once state is LOCK or BOOT.
REQ-028 A press edge SHALL be ignored in every state other than SEL.

Reset
REQ-029 Async rst SHALL force: state START, boot 0, fl_go 0, boot_sel DEF_IMG, fl_skip 0, sel_active 0, timer 0, long counter 0, registered btn copy 1.
REQ-030 rst asserted mid-LOCK or mid-BOOT SHALL abort cleanly; after release, behaviour SHALL match power-up.

Configuration
REQ-031 Macro BOOT_LONG_PRESS_EN defined: LONG_W-bit counter increments while btn_v=0 in SEL or SEL_WAIT, clears on btn_v=1; on reaching 2^(LONG_W-1), FSM SHALL go directly to LOCK (or BOOT if fl_skip) with current boot_sel, no timeout wait.
REQ-032 Macro BOOT_LONG_PRESS_EN undefined: no long counter logic; holding the button only delays the timeout (timer stays cleared).

Verification (N_IMG=3, DEF_IMG=2, SEL_IMG=1, TMR_W=8, REARM_W=4, LONG_W=10)
REQ-033 btn_v=1 through reset release -> fl_go pulse in cycle 1, fl_rdy raised 5 cycles later -> boot=1 one cycle after BOOT entry, boot_sel=2, fl_skip=0.
REQ-034 btn_v=0 at reset, release at cycle 20, no further press -> sel_active=1, SEL_WAIT 8 cycles, SEL 128 cycles, then fl_go, boot_sel=1.
REQ-035 In select mode, 2 presses each separated by >8 cycles -> boot_sel 1->2->0; third press -> boot_sel=1, fl_skip=1, timeout goes straight to BOOT, fl_go never asserted.
REQ-036 Press edge coincident with timeout tick in SEL -> SEL_WAIT entered, boot_sel incremented, no fl_go.
REQ-037 BOOT_LONG_PRESS_EN defined, hold btn_v=0 in SEL for 600 cycles -> after 512 held cycles fl_go pulse with boot_sel unchanged after the initial press increment; undefined -> no boot until 128 cycles after release.
REQ-038 rst asserted 3 cycles after fl_go, btn_v=1 -> state START, boot_sel=2, fresh fl_go after release.
